// File: rtl/my_pkg.sv
// Shared types for the ALU command path: the ALU opcode enum and the
// issuer FSM state enum.
package my_pkg;

    typedef enum logic [2:0] {
        A_NOP = 3'd0,
        A_ADD = 3'd1,
        A_SUB = 3'd2,
        A_AND = 3'd3,
        A_OR  = 3'd4,
        A_XOR = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } issuer_state_e;

    localparam int unsigned AluOpW = $bits(alu_op_e);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small synchronous FIFO holding packed {op, a, b} command entries.
// Pointers are log2(Depth) bits and wrap naturally; a separate occupancy
// count tells full from empty.
module alu_cmd_fifo #(
    parameter int unsigned Width = 19,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [AddrW:0] FullCnt = (AddrW+1)'(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [AddrW-1:0] r_wptr;
    logic [AddrW-1:0] r_rptr;
    logic [AddrW:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign full_o  = (r_count == FullCnt);
    assign empty_o = (r_count == '0);
    assign data_o  = r_mem[r_rptr];

    // Entry storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    // Pointer and occupancy tracking; push+pop together leaves the count alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AddrW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AddrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AddrW+1)'(1);
                2'b01:   r_count <= r_count - (AddrW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Initiator for the ALU operand/result interface: queues commands, issues
// one at a time to the ALU, waits for rvalid, and returns results in order.
// Optional macro ALU_CMD_ISSUER_CNT_EN adds a 32-bit completed-response
// counter on done_cnt_o.
module alu_cmd_issuer
    import my_pkg::*;
#(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned Depth     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [DataWidth-1:0] cmd_a_i,
    input  logic [DataWidth-1:0] cmd_b_i,
    input  alu_op_e              cmd_op_i,
    output logic [DataWidth-1:0] alu_a_o,
    output logic [DataWidth-1:0] alu_b_o,
    output alu_op_e              alu_op_o,
    output logic                 alu_dvalid_o,
    input  logic [DataWidth-1:0] alu_result_i,
    input  logic                 alu_rvalid_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_result_o,
    output logic                 busy_o
`ifdef ALU_CMD_ISSUER_CNT_EN
    ,
    output logic [31:0]          done_cnt_o
`endif
);

    localparam int unsigned EntryW = AluOpW + 2 * DataWidth;

    issuer_state_e        r_state;
    issuer_state_e        w_state_nxt;
    logic                 r_ready_en;
    logic [DataWidth-1:0] r_a;
    logic [DataWidth-1:0] r_b;
    alu_op_e              r_op;
    logic [DataWidth-1:0] r_result;

    logic [EntryW-1:0]    w_fifo_wdata;
    logic [EntryW-1:0]    w_fifo_rdata;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_capture;
    logic                 w_issue;

    assign w_push       = cmd_valid_i && cmd_ready_o;
    assign w_fifo_wdata = {cmd_op_i, cmd_a_i, cmd_b_i};

    alu_cmd_fifo #(
        .Width (EntryW),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (w_fifo_wdata),
        .pop_i   (w_pop),
        .data_o  (w_fifo_rdata),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; pops happen only when a new command can go straight to issue.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (alu_rvalid_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // cmd_ready stays low during reset and rises on the first clock after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    // Issue registers load the FIFO head on pop; outputs are gated by state.
    always_ff @(posedge clk_i) begin
        if (w_pop) begin
            r_op <= alu_op_e'(w_fifo_rdata[2*DataWidth +: AluOpW]);
            r_a  <= w_fifo_rdata[DataWidth +: DataWidth];
            r_b  <= w_fifo_rdata[0 +: DataWidth];
        end
    end

    // Result register captures the ALU result and holds it until accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_result <= '0;
        end else if (w_capture) begin
            r_result <= alu_result_i;
        end
    end

    assign w_issue      = (r_state == S_ISSUE);
    assign alu_dvalid_o = w_issue;
    assign alu_a_o      = w_issue ? r_a : '0;
    assign alu_b_o      = w_issue ? r_b : '0;
    assign alu_op_o     = w_issue ? r_op : A_NOP;
    assign rsp_valid_o  = (r_state == S_RESP);
    assign rsp_result_o = r_result;
    assign cmd_ready_o  = r_ready_en && !w_full;
    assign busy_o       = !w_empty || (r_state != S_IDLE);

`ifdef ALU_CMD_ISSUER_CNT_EN
    logic [31:0] r_done_cnt;

    // Completed-response counter, wraps naturally at 32 bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done_cnt <= '0;
        end else if (rsp_valid_o && rsp_ready_i) begin
            r_done_cnt <= r_done_cnt + 32'd1;
        end
    end

    assign done_cnt_o = r_done_cnt;
`endif

endmodule
